pio_access_arbiter: RTL and testbench
=====================================

Name: pio_access_arbiter

Overview:
Shares one Avalon-MM PIO slave port (2-bit address, 32-bit data, zero-wait, combinational readdata) between NUM_REQ requesters, e.g. the Nios bridge and the hardware ball/paddle engines. Round-robin grant, one transaction at a time, fixed 3-cycle sequence per access. Sits between the requesters and the PIO s1 slave port; the PIO's own reset_n is driven from the system reset elsewhere.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 2, PIO slave address width
DATA_W, 32, PIO data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_address  in  NUM_REQ*ADDR_W  flattened; requester i in [i*ADDR_W +: ADDR_W]
req_writedata  in  NUM_REQ*DATA_W  flattened, same slicing
req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
req_readdata  out  DATA_W  read result, valid only in the req_ack cycle
avm_address  out  ADDR_W  to PIO address
avm_chipselect  out  1  to PIO chipselect
avm_write_n  out  1  to PIO write_n (active low)
avm_writedata  out  DATA_W  to PIO writedata
avm_readdata  in  DATA_W  from PIO readdata
busy  out  1  high in GRANT and ACCESS
grant_id  out  $clog2(NUM_REQ)  index of the latched requester

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, except avm_write_n = 1. FSM goes to IDLE. last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANT, ACCESS, RESP.
- IDLE: if any req_valid is high, the picker selects the first valid index searching from last_grant+1 with modulo wrap. Latch index, write, address and writedata. Go to GRANT. Otherwise stay in IDLE.
- GRANT: drive avm_address, avm_writedata and avm_write_n (= ~write) from the latched values; avm_chipselect = 0 (address setup cycle). Go to ACCESS.
- ACCESS: avm_chipselect = 1 for exactly this cycle. A write commits at the closing edge. For a read, capture avm_readdata into the readdata register at the closing edge. Go to RESP.
- RESP: req_ack[grant_id] = 1; req_readdata = captured value (0 for writes). last_grant <= grant_id. Go to IDLE.
- Outside ACCESS: avm_chipselect = 0 and avm_write_n = 1. avm_address and avm_writedata hold their last values.
- Latency: from req_valid sampled in IDLE to req_ack is 3 cycles. Maximum throughput is one access per 4 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. Worst-case wait is NUM_REQ*4 cycles.
- Withdrawal: req_valid dropping before it is latched in IDLE has no effect. Once latched, the transaction completes and acks even if req_valid drops. Requesters treat their fields as consumed at ack.
- Simultaneous requests: only one is latched per IDLE cycle. Others wait; no ack is lost.
- A requester still holding req_valid in the cycle after its ack is re-arbitrated as a new request. This is legal, but it has the lowest priority unless it is the only requester.
- Reset mid-operation (GRANT/ACCESS/RESP): the transaction is abandoned and no ack is issued. avm_chipselect is 0 from the next cycle. A write in ACCESS during the reset cycle may commit at the PIO (same edge); software tolerates this.
- Width rules: grant_id is zero-extended in comparisons. The modulo wrap for non-power-of-2 NUM_REQ is explicit (no reliance on counter overflow).

Decomposition:
- Shared package pio_arb_pkg: state enum {IDLE, GRANT, ACCESS, RESP}; PIO_ADDR_W = 2; PIO_DATA_W = 32.
- Sub-module rr_picker. Inputs: req vector, last_grant. Outputs: found, index. Purely combinational; a double-width masked priority encode.
- Top level: FSM, latches, Avalon drive.

Test Plan:
- Reset: assert reset 2 cycles with req_valid = 2'b11 -> all acks 0, avm_chipselect 0, avm_write_n 1; first grant after release goes to requester 0.
- Single write: req0 write addr 0, data 32'h1 -> chipselect high exactly 1 cycle with write_n 0 and addr 0; ack0 3 cycles after request; PIO out_port = 1.
- Single read: after the previous step, req1 read addr 0 -> req_readdata = 32'h1 in the ack1 cycle. Read addr 1 -> 32'h0.
- Contention: both valid continuously, 6 transactions -> ack order 0,1,0,1,0,1; never two acks in one cycle; spacing 4 cycles.
- Withdrawal/late drop: req1 pulses valid 1 cycle while req0 is in ACCESS -> no ack1. req0 drops valid during ACCESS -> ack0 still issued and the write committed.
- Reset mid-access: reset in ACCESS -> no ack; chipselect 0 next cycle; FSM IDLE; last_grant restored so requester 0 wins the next contention.

Source files
------------

// File: rtl/pio_access_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | pio_arb_pkg: shared types and widths for the PIO access arbiter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pio_arb_pkg;

  localparam int PIO_ADDR_W = 2;
  localparam int PIO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pio_access_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | pio_access_arbiter_if: requester-side and Avalon-MM PIO-side signals.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pio_access_arbiter_if
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int DATA_W  = PIO_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_readdata;

  logic [ADDR_W-1:0]         avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [DATA_W-1:0]         avm_writedata;
  logic [DATA_W-1:0]         avm_readdata;

  // Requesters plus the PIO slave, as seen from outside the arbiter.
  modport master (
    output req_valid, req_write, req_address, req_writedata, avm_readdata,
    input  req_ack, req_readdata, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    input  req_valid, req_write, req_address, req_writedata, avm_readdata,
    output req_ack, req_readdata, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

endinterface

`default_nettype wire

// File: rtl/pio_access_arbiter_rr_picker.sv
// +----------------------------------------------------------------------------+
// | rr_picker: combinational round-robin picker, double-width masked encode.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;

  // Window (last_grant, last_grant+NUM_REQ] over the doubled vector gives the wrap.
  always_comb begin
    dbl   = {req, req};
    mask  = '0;
    found = 1'b0;
    index = '0;
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      mask[j] = (j > int'(last_grant)) && (j <= int'(last_grant) + NUM_REQ);
    end
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      if (!found && dbl[j] && mask[j]) begin
        found = 1'b1;
        index = (j >= NUM_REQ) ? IDX_W'(j - NUM_REQ) : IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pio_access_arbiter.sv
// +----------------------------------------------------------------------------+
// | pio_access_arbiter: round-robin sharing of one Avalon-MM PIO slave port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = PIO_ADDR_W,
  parameter  int DATA_W  = PIO_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_access_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id
);

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic               lat_write;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_index;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= IDX_W'(NUM_REQ - 1);
      lat_write          <= 1'b0;
      grant_id           <= '0;
      busy               <= 1'b0;
      bus.req_ack        <= '0;
      bus.req_readdata   <= '0;
      bus.avm_address    <= '0;
      bus.avm_writedata  <= '0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id          <= pick_index;
            lat_write         <= bus.req_write[pick_index];
            bus.avm_address   <= bus.req_address[pick_index*ADDR_W +: ADDR_W];
            bus.avm_writedata <= bus.req_writedata[pick_index*DATA_W +: DATA_W];
            bus.avm_write_n   <= ~bus.req_write[pick_index];
            busy              <= 1'b1;
            state             <= GRANT;
          end
        end
        GRANT: begin
          bus.avm_chipselect <= 1'b1;
          state              <= ACCESS;
        end
        ACCESS: begin
          // PIO readdata is combinational, so it is valid at this closing edge.
          bus.avm_chipselect <= 1'b0;
          bus.avm_write_n    <= 1'b1;
          busy               <= 1'b0;
          bus.req_ack        <= NUM_REQ'(1) << grant_id;
          bus.req_readdata   <= lat_write ? '0 : bus.avm_readdata;
          state              <= RESP;
        end
        RESP: begin
          bus.req_ack      <= '0;
          bus.req_readdata <= '0;
          last_grant       <= grant_id;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pio_access_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_pio_access_arbiter: scoreboard bench with a behavioural PIO slave.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pio_access_arbiter;
  import pio_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [0:0] grant_id;

  always #5 clk = ~clk;

  pio_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  pio_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // PIO: data register at address 0, other addresses read as zero
  logic [DW-1:0] pio_out = '0;
  always @(posedge clk)
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd0)
      pio_out <= bus.avm_writedata;
  assign bus.avm_readdata = (bus.avm_address == 2'd0) ? pio_out : '0;

  typedef struct packed {
    logic [0:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cs_cycles = 0;
  logic last_cs_wn = 1'b1;
  logic [AW-1:0] last_cs_addr = '0;
  bit   check_spacing = 1'b0;
  int   last_ack_cyc = -1;

  function automatic exp_t mk(int id, logic [DW-1:0] d);
    exp_t e;
    e.id   = 1'(id);
    e.data = d;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever an ack is presented
  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] exp_ack;
    if (bus.avm_chipselect) begin
      cs_cycles++;
      last_cs_wn   = bus.avm_write_n;
      last_cs_addr = bus.avm_address;
    end
    if (bus.req_ack != '0) begin
      checks++;
      if (!$onehot(bus.req_ack)) begin
        errors++;
        $display("FAIL ack_onehot: req_ack=%b, required one-hot", bus.req_ack);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: req_ack=%b with nothing expected", bus.req_ack);
      end else begin
        e = exp_q.pop_front();
        exp_ack = N'(1) << e.id;
        if (bus.req_ack != exp_ack || bus.req_readdata != e.data) begin
          errors++;
          $display("FAIL ack_data: got ack=%b data=%h, expected ack=%b data=%h",
                   bus.req_ack, bus.req_readdata, exp_ack, e.data);
        end
      end
      if (check_spacing && last_ack_cyc >= 0) begin
        checks++;
        if (cyc - last_ack_cyc != 4) begin
          errors++;
          $display("FAIL ack_spacing: got %0d cycles, expected 4", cyc - last_ack_cyc);
        end
      end
      last_ack_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(int id, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.req_ack[id] && n < 40);
    if (!bus.req_ack[id]) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: req %0d got no ack in %0d cycles, expected one", id, n);
    end
  endtask

  task automatic wait_cs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.avm_chipselect && n < 20);
    if (!bus.avm_chipselect) begin
      checks++;
      errors++;
      $display("FAIL cs_timeout: chipselect=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic set_req(int id, logic wr, logic [AW-1:0] addr, logic [DW-1:0] wd);
    bus.req_write[id]               = wr;
    bus.req_address[id*AW +: AW]    = addr;
    bus.req_writedata[id*DW +: DW]  = wd;
  endtask

  task automatic single(int id, logic wr, logic [AW-1:0] addr, logic [DW-1:0] wd,
                        logic [DW-1:0] exp_rd, output int lat);
    exp_q.push_back(mk(id, exp_rd));
    set_req(id, wr, addr, wd);
    bus.req_valid[id] = 1'b1;
    wait_ack(id, lat);
    bus.req_valid[id] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int lat;
    int c0;
    logic [DW-1:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};

    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_address   = '0;
    bus.req_writedata = '0;

    // Reset held with both requesters asking
    set_req(0, 1'b0, 2'd1, '0);
    set_req(1, 1'b0, 2'd1, '0);
    bus.req_valid = 2'b11;
    reset = 1'b1;
    tick();
    tick();
    check("rst_ack", bus.req_ack, 0);
    check("rst_cs", bus.avm_chipselect, 0);
    check("rst_write_n", bus.avm_write_n, 1);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    exp_q.push_back(mk(0, 32'h0));
    exp_q.push_back(mk(1, 32'h0));
    reset = 1'b0;
    wait_ack(0, lat);
    bus.req_valid[0] = 1'b0;
    wait_ack(1, lat);
    bus.req_valid[1] = 1'b0;
    tick();
    tick();

    // Single write then reads
    c0 = cs_cycles;
    single(0, 1'b1, 2'd0, 32'h1, 32'h0, lat);
    check("write_latency", lat, 3);
    check("write_cs_cycles", cs_cycles - c0, 1);
    check("write_cs_write_n", last_cs_wn, 0);
    check("write_cs_addr", last_cs_addr, 0);
    check("pio_after_write", pio_out, 32'h1);
    c0 = cs_cycles;
    single(1, 1'b0, 2'd0, '0, 32'h1, lat);
    check("read_latency", lat, 3);
    check("read_cs_write_n", last_cs_wn, 1);
    single(1, 1'b0, 2'd1, '0, 32'h0, lat);
    check("read_cs_addr", last_cs_addr, 1);

    // Contention: both held valid, expect strict alternation
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 32'h0));
      exp_q.push_back(mk(1, vals[k]));
    end
    check_spacing = 1'b1;
    last_ack_cyc  = -1;
    set_req(1, 1'b0, 2'd0, '0);
    fork
      begin
        int n0;
        for (int k = 0; k < 3; k++) begin
          set_req(0, 1'b1, 2'd0, vals[k]);
          bus.req_valid[0] = 1'b1;
          wait_ack(0, n0);
        end
        bus.req_valid[0] = 1'b0;
      end
      begin
        int n1;
        bus.req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) wait_ack(1, n1);
        bus.req_valid[1] = 1'b0;
      end
    join
    check_spacing = 1'b0;
    tick();
    tick();

    // Late drop of req0 during ACCESS, stray one-cycle pulse from req1
    exp_q.push_back(mk(0, 32'h0));
    set_req(0, 1'b1, 2'd0, 32'hAB);
    set_req(1, 1'b0, 2'd0, '0);
    bus.req_valid[0] = 1'b1;
    wait_cs();
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1;
    tick();
    bus.req_valid[1] = 1'b0;
    check("late_drop_ack", bus.req_ack, 2'b01);
    repeat (8) tick();
    check("late_drop_commit", pio_out, 32'hAB);
    check("late_drop_no_pending", exp_q.size(), 0);

    // Reset in ACCESS abandons the transaction
    set_req(0, 1'b1, 2'd0, 32'h77);
    bus.req_valid[0] = 1'b1;
    wait_cs();
    reset = 1'b1;
    bus.req_valid[0] = 1'b0;
    tick();
    check("midrst_cs", bus.avm_chipselect, 0);
    check("midrst_ack", bus.req_ack, 0);
    reset = 1'b0;
    tick();
    check("midrst_busy", busy, 0);

    // last_grant restored: requester 0 must win next contention
    exp_q.push_back(mk(0, 32'h0));
    exp_q.push_back(mk(1, 32'h0));
    set_req(0, 1'b0, 2'd1, '0);
    set_req(1, 1'b0, 2'd1, '0);
    bus.req_valid = 2'b11;
    fork
      begin
        int n2;
        wait_ack(0, n2);
        bus.req_valid[0] = 1'b0;
      end
      begin
        int n3;
        wait_ack(1, n3);
        bus.req_valid[1] = 1'b0;
      end
    join
    repeat (6) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
